// File: rtl/sound_cmd_bridge.sv
// sound_cmd_bridge: 68000 -> Z80 sound command FIFO with Z80 IRQ and 68k status port
//   m68k_latch_cs/m68k_lds_n/m68k_din : 68k command write (push on strobe rise)
//   m68k_sound_cs/m68k_dout           : 68k status read {ovf, full, empty, 0, count}
//   z80_latch_cs/z80_rd_n/z80_dout    : Z80 command read (pop at end of read)
//   z80_m1_n/z80_iorq_n/z80_irq_n     : Z80 interrupt request and acknowledge
module sound_cmd_bridge #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [7:0]  IRQ_VEC = 8'hff
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m68k_latch_cs,
    input  logic       m68k_lds_n,
    input  logic [7:0] m68k_din,
    input  logic       m68k_sound_cs,
    output logic [7:0] m68k_dout,
    input  logic       z80_latch_cs,
    input  logic       z80_rd_n,
    input  logic       z80_m1_n,
    input  logic       z80_iorq_n,
    output logic [7:0] z80_dout,
    output logic       z80_irq_n
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic wr, rd, st, ack;
    assign wr  = m68k_latch_cs & ~m68k_lds_n;
    assign rd  = z80_latch_cs & ~z80_rd_n;
    assign st  = m68k_sound_cs;
    assign ack = ~z80_m1_n & ~z80_iorq_n;

    logic          wr_h_q, wr_h_d, rd_h_q, rd_h_d, st_h_q, st_h_d, ack_h_q, ack_h_d;
    logic          rd_arm_q, rd_arm_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, irq_pend_q, irq_pend_d, mask_q, mask_d;
    logic [7:0]    last_q, last_d;
    logic [7:0]    mem_q [DEPTH];

    logic empty, full, wr_rise, push, pop, ovf_set, ack_rise, st_fall;
    assign empty    = count_q == '0;
    assign full     = count_q == CW'(DEPTH);
    assign wr_rise  = wr & ~wr_h_q;
    assign ack_rise = ack & ~ack_h_q;
    assign st_fall  = ~st & st_h_q;
    // A pop needs a read whose start was seen after reset, so a read straddling reset is ignored
    assign pop      = ~rd & rd_h_q & rd_arm_q & ~empty;
    // A pop in the same clock frees the slot a push-while-full needs
    assign push     = wr_rise & (~full | pop);
    assign ovf_set  = wr_rise & full & ~pop;

    always_comb begin
        wr_h_d     = wr;
        rd_h_d     = rd;
        st_h_d     = st;
        ack_h_d    = ack;
        rd_arm_d   = (rd & ~rd_h_q) | (rd_arm_q & rd);
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        ovf_d      = ovf_set | (ovf_q & ~st_fall);
        last_d     = pop ? mem_q[rptr_q] : last_q;
        mask_d     = pop ? 1'b0 : (ack_rise | mask_q);
        // Request rises a clock after count is nonzero and unmasked; drops as soon as count hits 0
        irq_pend_d = (count_d != '0) & ~ack_rise & (irq_pend_q | (~empty & ~mask_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_h_q     <= 1'b1;
            rd_h_q     <= 1'b1;
            st_h_q     <= 1'b1;
            ack_h_q    <= 1'b1;
            rd_arm_q   <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            last_q     <= 8'h00;
            mask_q     <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            wr_h_q     <= wr_h_d;
            rd_h_q     <= rd_h_d;
            st_h_q     <= st_h_d;
            ack_h_q    <= ack_h_d;
            rd_arm_q   <= rd_arm_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
            mask_q     <= mask_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wptr_q] <= m68k_din;
    end

    logic [3:0] cnt4;
    assign cnt4      = 4'(count_q);
    assign m68k_dout = st ? {ovf_q, full, empty, 1'b0, cnt4} : 8'h00;
    assign z80_irq_n = ~irq_pend_q;
    // Read data is taken from the head while rd is high; the pointer only moves when rd ends
    assign z80_dout  = ack ? IRQ_VEC : rd ? (empty ? last_q : mem_q[rptr_q]) : 8'h00;
endmodule

// File: tb/tb_sound_cmd_bridge.sv
// tb_sound_cmd_bridge: directed and random checks of sound_cmd_bridge against a queue model
module tb_sound_cmd_bridge;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m68k_latch_cs = 1'b0, m68k_lds_n = 1'b1, m68k_sound_cs = 1'b0;
    logic [7:0] m68k_din = 8'h00;
    logic       z80_latch_cs = 1'b0, z80_rd_n = 1'b1, z80_m1_n = 1'b1, z80_iorq_n = 1'b1;
    logic [7:0] m68k_dout, z80_dout;
    logic       z80_irq_n;

    sound_cmd_bridge #(.DEPTH(4), .IRQ_VEC(8'hff)) dut (
        .clk(clk), .reset(reset),
        .m68k_latch_cs(m68k_latch_cs), .m68k_lds_n(m68k_lds_n), .m68k_din(m68k_din),
        .m68k_sound_cs(m68k_sound_cs), .m68k_dout(m68k_dout),
        .z80_latch_cs(z80_latch_cs), .z80_rd_n(z80_rd_n), .z80_m1_n(z80_m1_n),
        .z80_iorq_n(z80_iorq_n), .z80_dout(z80_dout), .z80_irq_n(z80_irq_n)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_mask = 1'b0;
    logic [7:0] m_last = 8'h00;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_mask = 1'b0;
        m_last = 8'h00;
        tick();
    endtask

    task automatic do_write(input logic [7:0] b);
        m68k_din = b;
        m68k_latch_cs = 1'b1;
        m68k_lds_n = 1'b0;
        repeat (3) tick();
        m68k_latch_cs = 1'b0;
        m68k_lds_n = 1'b1;
        tick();
        if (q.size() < 4) q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic do_read(input string tag);
        logic [7:0] v;
        z80_latch_cs = 1'b1;
        z80_rd_n = 1'b0;
        tick();
        v = z80_dout;
        z80_latch_cs = 1'b0;
        z80_rd_n = 1'b1;
        tick();
        check(tag, v, q.size() != 0 ? q[0] : m_last);
        if (q.size() != 0) begin
            m_last = q.pop_front();
            m_mask = 1'b0;
        end
    endtask

    task automatic do_status(input string tag);
        logic [7:0] s;
        logic [3:0] n;
        m68k_sound_cs = 1'b1;
        tick();
        s = m68k_dout;
        m68k_sound_cs = 1'b0;
        tick();
        n = 4'(q.size());
        check(tag, s, {m_ovf, q.size() == 4, q.size() == 0, 1'b0, n});
        m_ovf = 1'b0;
    endtask

    task automatic do_ack();
        z80_m1_n = 1'b0;
        z80_iorq_n = 1'b0;
        tick();
        check("ack_vec", z80_dout, 8'hff);
        check("ack_irq", 8'(z80_irq_n), 8'h01);
        z80_m1_n = 1'b1;
        z80_iorq_n = 1'b1;
        tick();
        m_mask = 1'b1;
    endtask

    task automatic chk_irq(input string tag);
        tick();
        check(tag, 8'(z80_irq_n), 8'((q.size() != 0 && !m_mask) ? 0 : 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v, nb;
        do_reset();
        check("rst_m68k_dout", m68k_dout, 8'h00);
        check("rst_z80_dout", z80_dout, 8'h00);
        check("rst_irq_n", 8'(z80_irq_n), 8'h01);
        do_status("rst_status");

        // 1: single command, strobe held 3 clocks
        do_reset();
        m68k_din = 8'h12;
        m68k_latch_cs = 1'b1;
        m68k_lds_n = 1'b0;
        tick();
        check("t1_irq_pre", 8'(z80_irq_n), 8'h01);
        tick();
        check("t1_irq_fall", 8'(z80_irq_n), 8'h00);
        tick();
        m68k_latch_cs = 1'b0;
        m68k_lds_n = 1'b1;
        tick();
        q.push_back(8'h12);
        do_status("t1_status");
        do_read("t1_read");
        check("t1_irq_clr", 8'(z80_irq_n), 8'h01);
        do_status("t1_status_empty");

        // 2: overflow, drain, empty read, read-to-clear ovf
        do_reset();
        for (int i = 1; i <= 5; i++) do_write(8'(i));
        do_status("t2_status_ovf");
        do_status("t2_status_clr");
        for (int i = 0; i < 5; i++) do_read("t2_read");
        do_status("t2_status_end");

        // 3: push and pop in the same clock while full
        do_reset();
        for (int i = 0; i < 4; i++) do_write(8'($urandom_range(0, 255)));
        nb = 8'($urandom_range(0, 255));
        z80_latch_cs = 1'b1;
        z80_rd_n = 1'b0;
        tick();
        v = z80_dout;
        m68k_din = nb;
        m68k_latch_cs = 1'b1;
        m68k_lds_n = 1'b0;
        z80_latch_cs = 1'b0;
        z80_rd_n = 1'b1;
        tick();
        tick();
        m68k_latch_cs = 1'b0;
        m68k_lds_n = 1'b1;
        tick();
        check("t3_read", v, q[0]);
        m_last = q.pop_front();
        q.push_back(nb);
        do_status("t3_status");
        for (int i = 0; i < 4; i++) do_read("t3_drain");

        // 4: interrupt acknowledge masks until the next pop
        do_reset();
        do_write(8'h31);
        do_write(8'h32);
        chk_irq("t4_irq_pend");
        do_ack();
        chk_irq("t4_irq_masked");
        do_read("t4_read1");
        chk_irq("t4_irq_again");
        do_read("t4_read2");
        chk_irq("t4_irq_done");

        // 5: reset with a Z80 read in progress
        do_reset();
        for (int i = 0; i < 3; i++) do_write(8'(8'h40 + i));
        z80_latch_cs = 1'b1;
        z80_rd_n = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_mask = 1'b0;
        m_last = 8'h00;
        tick();
        check("t5_irq_n", 8'(z80_irq_n), 8'h01);
        do_write(8'h5a);
        z80_latch_cs = 1'b0;
        z80_rd_n = 1'b1;
        tick();
        tick();
        do_status("t5_no_pop");
        do_read("t5_read_5a");
        do_write(8'ha5);
        do_read("t5_read_a5");
        do_status("t5_status");

        // 6: pointer wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_write(8'(i));
            do_read("t6_read");
        end
        do_status("t6_status");

        // random traffic against the queue model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_write(8'($urandom_range(0, 255)));
                4, 5, 6:    do_read("rnd_read");
                7, 8:       do_status("rnd_status");
                default:    do_ack();
            endcase
            chk_irq("rnd_irq");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
